fetch: RTL and testbench

//  IF stage of the 5-stage RV32I pipeline; producer side of fetch_dec_reg consumed by decode.

---
 rtl/fetch.sv | 100 ++++++++++
 tb/tb_fetch.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fetch.sv
// IF stage of the RV32I pipeline: PC register, instruction pre-decode,
// 2-bit BHT branch prediction and the fetch/decode pipeline register.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned BHT_BITS = 6
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        update_en,
  input  logic [31:0] update_pc,
  input  logic        update_taken,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [64:0] fetch_dec_reg
);

  localparam int unsigned XLEN        = 32;
  localparam int unsigned BHT_ENTRIES = 1 << BHT_BITS;
  localparam logic [6:0]  OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0]  OPC_JAL     = 7'b1101111;

  logic [XLEN-1:0]     pc;
  logic [XLEN-1:0]     next_pc;
  logic [XLEN-1:0]     imm;
  logic                pred;
  logic [BHT_BITS-1:0] lookup_idx;
  logic [BHT_BITS-1:0] update_idx;
  logic [1:0]          bht [BHT_ENTRIES];
  logic                unused_update_bits;

  assign imem_addr  = pc;
  assign lookup_idx = pc[BHT_BITS+1:2];
  assign update_idx = update_pc[BHT_BITS+1:2];

  // Only the index bits of the update PC select a counter; the rest are ignored.
  assign unused_update_bits = ^{update_pc[XLEN-1:BHT_BITS+2], update_pc[1:0]};

  // Pre-decode: immediate extraction and taken prediction for B-type and JAL.
  always_comb begin
    imm  = '0;
    pred = 1'b0;
    case (imem_data[6:0])
      OPC_BRANCH: begin
        imm  = {{20{imem_data[31]}}, imem_data[7], imem_data[30:25], imem_data[11:8], 1'b0};
        pred = bht[lookup_idx][1];
      end
      OPC_JAL: begin
        imm  = {{12{imem_data[31]}}, imem_data[19:12], imem_data[20], imem_data[30:21], 1'b0};
        pred = 1'b1;
      end
      default: begin
        imm  = '0;
        pred = 1'b0;
      end
    endcase
  end

  // Next sequential or predicted-target PC; wraps modulo 2^32.
  always_comb begin
    next_pc = pc + XLEN'(4);
    if (pred) begin
      next_pc = pc + imm;
    end
  end

  // PC and fetch/decode register: redirect beats stall, stall beats normal fetch.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc            <= RESET_PC;
      fetch_dec_reg <= '0;
    end else if (redirect_en) begin
      pc            <= redirect_pc;
      fetch_dec_reg <= '0;
    end else if (!stall) begin
      pc            <= next_pc;
      fetch_dec_reg <= {imem_data, pc, pred};
    end
  end

  // BHT training from resolved branches; lookup this cycle sees the old value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
        bht[BHT_BITS'(i)] <= 2'b01;
      end
    end else if (update_en) begin
      if (update_taken) begin
        if (bht[update_idx] != 2'b11) begin
          bht[update_idx] <= bht[update_idx] + 2'd1;
        end
      end else if (bht[update_idx] != 2'b00) begin
        bht[update_idx] <= bht[update_idx] - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Directed self-checking bench for the fetch stage.
module tb_fetch;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] JAL16  = 32'h0100_006F;
  localparam logic [31:0] BEQ8   = 32'h0000_0463;
  localparam logic [31:0] BEQM8  = 32'hFE00_0CE3;
  localparam logic [31:0] RET    = 32'h0000_8067;

  logic        clk;
  logic        rstn;
  logic        stall;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        update_en;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [64:0] fetch_dec_reg;

  int compared;
  int mismatched;

  fetch #(.RESET_PC(32'h0000_0100), .BHT_BITS(6)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .stall        (stall),
    .redirect_en  (redirect_en),
    .redirect_pc  (redirect_pc),
    .update_en    (update_en),
    .update_pc    (update_pc),
    .update_taken (update_taken),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .fetch_dec_reg(fetch_dec_reg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [31:0] epc, input logic [64:0] ereg);
    chk({tag, ".pc"}, {33'b0, imem_addr}, {33'b0, epc});
    chk({tag, ".reg"}, fetch_dec_reg, ereg);
  endtask

  initial begin
    compared     = 0;
    mismatched   = 0;
    rstn         = 1'b1;
    stall        = 1'b0;
    redirect_en  = 1'b0;
    redirect_pc  = '0;
    update_en    = 1'b0;
    update_pc    = '0;
    update_taken = 1'b0;
    imem_data    = NOP;

    // T1: asynchronous reset, then NOP stream
    #2 rstn = 1'b0;
    #1 chk_state("t1_async_reset", 32'h100, 65'b0);
    step();
    chk_state("t1_reset_held", 32'h100, 65'b0);
    rstn = 1'b1;
    step();
    chk_state("t1_nop0", 32'h104, {NOP, 32'h100, 1'b0});
    imem_data = RET;
    step();
    chk_state("t1_jalr_no_pred", 32'h108, {RET, 32'h104, 1'b0});

    // T2: JAL always predicted taken
    redirect_en = 1'b1; redirect_pc = 32'h100;
    step();
    chk_state("t2_redirect", 32'h100, 65'b0);
    redirect_en = 1'b0; imem_data = JAL16;
    step();
    chk_state("t2_jal", 32'h110, {JAL16, 32'h100, 1'b1});

    // T5: same-cycle lookup and update of counter 01 at 0x200
    redirect_en = 1'b1; redirect_pc = 32'h200;
    step();
    redirect_en = 1'b0; imem_data = BEQ8;
    update_en = 1'b1; update_pc = 32'h200; update_taken = 1'b1;
    step();
    chk_state("t5_pre_update_pred", 32'h204, {BEQ8, 32'h200, 1'b0});
    update_en = 1'b0;
    redirect_en = 1'b1; redirect_pc = 32'h200;
    step();
    redirect_en = 1'b0;
    step();
    chk_state("t5_refetch_pred", 32'h208, {BEQ8, 32'h200, 1'b1});

    // T3: saturate at 11, then train down to 00
    imem_data = NOP; stall = 1'b1;
    update_en = 1'b1; update_taken = 1'b1;
    repeat (3) step();
    chk_state("t3_stall_hold", 32'h208, {BEQ8, 32'h200, 1'b1});
    update_taken = 1'b0;
    step();
    update_en = 1'b0; stall = 1'b0;
    redirect_en = 1'b1; redirect_pc = 32'h200;
    step();
    redirect_en = 1'b0; imem_data = BEQ8;
    step();
    chk_state("t3_sat11_minus1", 32'h208, {BEQ8, 32'h200, 1'b1});
    stall = 1'b1; update_en = 1'b1; update_taken = 1'b0;
    repeat (3) step();
    update_en = 1'b0; stall = 1'b0;
    redirect_en = 1'b1; redirect_pc = 32'h200;
    step();
    redirect_en = 1'b0;
    step();
    chk_state("t3_trained_nt", 32'h204, {BEQ8, 32'h200, 1'b0});

    // T4: redirect overrides stall, then stall holds
    stall = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h400;
    step();
    chk_state("t4_redirect_over_stall", 32'h400, 65'b0);
    stall = 1'b0; redirect_en = 1'b0; imem_data = NOP;
    step();
    chk_state("t4_fetch", 32'h404, {NOP, 32'h400, 1'b0});
    stall = 1'b1; imem_data = JAL16;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_state("t4_stall", 32'h404, {NOP, 32'h400, 1'b0});
    end
    stall = 1'b0;

    // T6: PC wrap on sequential and backward-branch paths
    redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFC; imem_data = NOP;
    step();
    redirect_en = 1'b0;
    step();
    chk_state("t6_wrap_seq", 32'h0, {NOP, 32'hFFFF_FFFC, 1'b0});
    update_en = 1'b1; update_pc = 32'h4; update_taken = 1'b1;
    step();
    chk_state("t6_nop_at_0", 32'h4, {NOP, 32'h0, 1'b0});
    update_en = 1'b0; imem_data = BEQM8;
    step();
    chk_state("t6_wrap_branch", 32'hFFFF_FFFC, {BEQM8, 32'h4, 1'b1});

    // Misaligned redirect is loaded unchanged
    redirect_en = 1'b1; redirect_pc = 32'h0000_0202; imem_data = NOP;
    step();
    chk_state("misaligned_redirect", 32'h202, 65'b0);
    redirect_en = 1'b0;
    step();
    chk_state("misaligned_seq", 32'h206, {NOP, 32'h202, 1'b0});

    // Mid-operation asynchronous reset, away from the clock edge; BHT back to 01
    #2 rstn = 1'b0;
    #1 chk_state("mid_reset", 32'h100, 65'b0);
    step();
    rstn = 1'b1;
    redirect_en = 1'b1; redirect_pc = 32'h4;
    step();
    redirect_en = 1'b0; imem_data = BEQM8;
    step();
    chk_state("bht_reset_weak_nt", 32'h8, {BEQM8, 32'h4, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
